rf_access_bridge: RTL and testbench

Host-side bridge that sits directly upstream of a generated register file (e.g. the counter RF holding the 48-bit `tsc_cnt` register). It accepts single register read/write requests on a valid/ready channel, drives the register file's one-cycle `read_en`/`write_en` strobe interface, waits for `access_complete` with a bounded timeout, and returns exactly one response per request. Exactly one access is outstanding at a time.

---
 rtl/rf_bridge_pkg.sv | 17 +
 rtl/rf_access_bridge.sv | 176 +++++++++++++++++
 tb/tb_rf_access_bridge.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_bridge_pkg.sv
// Shared definitions for the register-file access bridge.
//   state_e      : bridge FSM states
//   RSP_*        : encodings driven on rsp_error
package rf_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_INVALID = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;

endpackage

// File: rtl/rf_access_bridge.sv
// Host-side bridge in front of a generated register file.
// Takes one read/write request at a time on a valid/ready channel, fires a
// single-cycle read_en/write_en strobe into the RF, waits (bounded) for
// access_complete and returns exactly one response per request.
//
// Ports
//   clk, res                 : clock (rising edge), async active-high reset
//   req_valid/req_ready      : request handshake
//   req_write/addr/wdata     : request payload (1 = write)
//   rsp_valid/rsp_ready      : response handshake
//   rsp_rdata/rsp_error      : read data (0 for writes/errors), status code
//   rf_address/read_en/write_en/write_data : RF command side
//   rf_read_data/invalid_address/access_complete : RF status side
//   stray_complete           : pulse when access_complete arrives with
//                              nothing pending (e.g. after a timeout)
module rf_access_bridge
  import rf_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_error,
  output logic [ADDR_WIDTH-1:0] rf_address,
  output logic                  rf_read_en,
  output logic                  rf_write_en,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  input  logic                  rf_invalid_address,
  input  logic                  rf_access_complete,
  output logic                  stray_complete
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  op_write_q, op_write_d;
  logic [ADDR_WIDTH-1:0] rf_address_q, rf_address_d;
  logic [DATA_WIDTH-1:0] rf_write_data_q, rf_write_data_d;
  logic                  rf_read_en_q, rf_read_en_d;
  logic                  rf_write_en_q, rf_write_en_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_error_q, rsp_error_d;
  logic                  stray_q, stray_d;

  // Response fields for a completing access: invalid address overrides data,
  // writes never return data.
  logic [DATA_WIDTH-1:0] cap_rdata;
  logic [1:0]            cap_error;

  always_comb begin
    cap_error = rf_invalid_address ? RSP_INVALID : RSP_OK;
    cap_rdata = (rf_invalid_address || op_write_q) ? '0 : rf_read_data;
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    op_write_d      = op_write_q;
    rf_address_d    = rf_address_q;
    rf_write_data_d = rf_write_data_q;
    rf_read_en_d    = 1'b0;
    rf_write_en_d   = 1'b0;
    rsp_valid_d     = rsp_valid_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_error_d     = rsp_error_q;
    stray_d         = rf_access_complete &&
                      ((state_q == ST_IDLE) || (state_q == ST_RESP));

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_write_d      = req_write;
          rf_address_d    = req_addr;
          rf_write_data_d = req_wdata;
          // Strobe flops are loaded here so they are high exactly in ISSUE.
          rf_read_en_d    = !req_write;
          rf_write_en_d   = req_write;
          state_d         = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rf_access_complete) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = cap_rdata;
          rsp_error_d = cap_error;
          state_d     = ST_RESP;
        end else begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The counter holds k-1 in the k-th WAIT cycle, so the give-up
        // decision lands in WAIT cycle TIMEOUT_CYCLES+1 and rsp_valid rises
        // TIMEOUT_CYCLES+2 cycles after the strobe. Completion is tested
        // first so it wins a tie with the threshold.
        if (rf_access_complete) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = cap_rdata;
          rsp_error_d = cap_error;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_LIMIT) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_error_d = RSP_TIMEOUT;
          state_d     = ST_RESP;
        end else begin
          cnt_d = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + CNT_ONE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      op_write_q      <= 1'b0;
      rf_address_q    <= '0;
      rf_write_data_q <= '0;
      rf_read_en_q    <= 1'b0;
      rf_write_en_q   <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_error_q     <= RSP_OK;
      stray_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      op_write_q      <= op_write_d;
      rf_address_q    <= rf_address_d;
      rf_write_data_q <= rf_write_data_d;
      rf_read_en_q    <= rf_read_en_d;
      rf_write_en_q   <= rf_write_en_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_error_q     <= rsp_error_d;
      stray_q         <= stray_d;
    end
  end

  // IDLE alone would read as ready during reset; gate it so the host never
  // sees ready while the bridge is held in reset.
  assign req_ready      = (state_q == ST_IDLE) && !res;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_error      = rsp_error_q;
  assign rf_address     = rf_address_q;
  assign rf_read_en     = rf_read_en_q;
  assign rf_write_en    = rf_write_en_q;
  assign rf_write_data  = rf_write_data_q;
  assign stray_complete = stray_q;

endmodule

// File: tb/tb_rf_access_bridge.sv
module tb_rf_access_bridge;
  import rf_bridge_pkg::*;

  localparam int AW = 8;
  localparam int DW = 64;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_error;
  logic [AW-1:0] rf_address;
  logic          rf_read_en;
  logic          rf_write_en;
  logic [DW-1:0] rf_write_data;
  logic [DW-1:0] rf_read_data = '0;
  logic          rf_invalid_address = 1'b0;
  logic          rf_access_complete = 1'b0;
  logic          stray_complete;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rf_access_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .res(res),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .rf_address(rf_address), .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
    .rf_write_data(rf_write_data), .rf_read_data(rf_read_data),
    .rf_invalid_address(rf_invalid_address),
    .rf_access_complete(rf_access_complete),
    .stray_complete(stray_complete)
  );

  // delay: cycle index (0 = strobe cycle) in which the RF raises
  // access_complete; -1 = never. lat: index in which rsp_valid must be seen.
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;
    logic          invalid;
    logic [DW-1:0] rf_rdata;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_err;
    int            lat;
    int            ready_wait;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int got;
    int strobes;
    logic [DW-1:0] rd0;
    logic [1:0]    er0;
    got = -1;
    strobes = 0;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    rf_read_data = v.rf_rdata;
    @(negedge clk);
    req_valid = 1'b0;
    for (int idx = 0; idx < 60; idx++) begin
      if (rf_read_en || rf_write_en) strobes++;
      if (idx == 0) begin
        check("strobe_rd", rf_read_en, !v.wr);
        check("strobe_wr", rf_write_en, v.wr);
        check("rf_address", rf_address, v.addr);
        if (v.wr) check("rf_write_data", rf_write_data, v.wdata);
      end
      if (rsp_valid) begin
        got = idx;
        rf_access_complete = 1'b0;
        rf_invalid_address = 1'b0;
        break;
      end
      rf_access_complete = (idx == v.delay);
      rf_invalid_address = (idx == v.delay) && v.invalid;
      @(negedge clk);
    end
    rf_access_complete = 1'b0;
    rf_invalid_address = 1'b0;
    check("rsp_latency", got, v.lat);
    check("strobe_count", strobes, 1);
    check("rsp_rdata", rsp_rdata, v.exp_rdata);
    check("rsp_error", rsp_error, v.exp_err);
    check("no_stray_on_rsp", stray_complete, 1'b0);
    rd0 = rsp_rdata;
    er0 = rsp_error;
    for (int i = 0; i < v.ready_wait; i++) begin
      @(negedge clk);
      check("rsp_hold_valid", rsp_valid, 1'b1);
      check("rsp_hold_rdata", rsp_rdata, rd0);
      check("rsp_hold_error", rsp_error, er0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_dropped", rsp_valid, 1'b0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 8'h10, 64'h0, 0, 1'b0, 64'h0000_1234_5678_9ABC,
                64'h0000_1234_5678_9ABC, RSP_OK, 1, 0};
    vecs[1] = '{1'b1, 8'h01, 64'hDEAD_BEEF, 3, 1'b0, 64'h5555_5555_5555_5555,
                64'h0, RSP_OK, 4, 0};
    vecs[2] = '{1'b0, 8'hFF, 64'h0, 0, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA,
                64'h0, RSP_INVALID, 1, 0};
    vecs[3] = '{1'b0, 8'h22, 64'h0, 5, 1'b0, 64'hFEDC_BA98_7654_3210,
                64'hFEDC_BA98_7654_3210, RSP_OK, 6, 2};
    vecs[4] = '{1'b1, 8'h80, 64'h1357_9BDF, 2, 1'b1, 64'h0,
                64'h0, RSP_INVALID, 3, 0};
    // Completion in the same cycle as the timeout threshold: completion wins.
    vecs[5] = '{1'b0, 8'h44, 64'h0, TO + 1, 1'b0, 64'h0123_4567_89AB_CDEF,
                64'h0123_4567_89AB_CDEF, RSP_OK, TO + 2, 0};
    vecs[6] = '{1'b0, 8'h55, 64'h0, -1, 1'b0, 64'h7777_7777_7777_7777,
                64'h0, RSP_TIMEOUT, TO + 2, 0};

    // Reset values
    #2 res = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 64'h0);
    check("rst_rsp_error", rsp_error, 2'b00);
    check("rst_rf_read_en", rf_read_en, 1'b0);
    check("rst_rf_write_en", rf_write_en, 1'b0);
    check("rst_stray", stray_complete, 1'b0);
    repeat (2) @(negedge clk);
    res = 1'b0;
    #1 check("rel_req_ready", req_ready, 1'b1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Late completion after the timeout response: stray pulse only.
    repeat (3) @(negedge clk);
    rf_access_complete = 1'b1;
    @(negedge clk);
    rf_access_complete = 1'b0;
    check("stray_pulse", stray_complete, 1'b1);
    check("stray_no_rsp", rsp_valid, 1'b0);
    check("stray_no_strobe", rf_read_en | rf_write_en, 1'b0);
    @(negedge clk);
    check("stray_clear", stray_complete, 1'b0);
    check("stray_no_rsp2", rsp_valid, 1'b0);

    // Back-pressure: rsp_ready low 10 cycles, req_valid kept high.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h66;
    rf_read_data = 64'h0BAD_F00D_1111_2222;
    @(negedge clk);
    check("bp_strobe", rf_read_en, 1'b1);
    rf_access_complete = 1'b1;
    @(negedge clk);
    rf_access_complete = 1'b0;
    rf_read_data = 64'h9999_9999_9999_9999;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_rdata", rsp_rdata, 64'h0BAD_F00D_1111_2222);
      check("bp_error", rsp_error, RSP_OK);
      check("bp_req_ready", req_ready, 1'b0);
      check("bp_no_strobe", rf_read_en | rf_write_en, 1'b0);
      if (i == 5) check("bp_stray", stray_complete, 1'b1);
      rf_access_complete = (i == 4);
      @(negedge clk);
    end
    rf_access_complete = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_released", rsp_valid, 1'b0);
    check("bp_idle_ready", req_ready, 1'b1);

    // Reset while waiting on the RF.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h33; req_wdata = 64'h4242;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 res = 1'b1;
    #1;
    check("mid_req_ready", req_ready, 1'b0);
    check("mid_rsp_valid", rsp_valid, 1'b0);
    check("mid_rsp_rdata", rsp_rdata, 64'h0);
    check("mid_rf_address", rf_address, 8'h00);
    check("mid_rf_wdata", rf_write_data, 64'h0);
    check("mid_strobes", rf_read_en | rf_write_en, 1'b0);
    @(negedge clk);
    res = 1'b0;
    #1 check("mid_rel_ready", req_ready, 1'b1);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
